// File: rtl/regfile_sb.sv
// Integer register file with two write ports, write-to-read bypass
// and a per-register pending scoreboard for decode stall control.
module regfile_sb #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [AW-1:0]   ra1,
   input  logic [AW-1:0]   ra2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   output logic            rd_pend1,
   output logic            rd_pend2,
   input  logic            we_a,
   input  logic [AW-1:0]   wa_a,
   input  logic [XLEN-1:0] wd_a,
   input  logic            we_b,
   input  logic [AW-1:0]   wa_b,
   input  logic [XLEN-1:0] wd_b,
   input  logic            iss_valid,
   input  logic [AW-1:0]   iss_rd,
   input  logic            flush,
   output logic [AW:0]     pend_cnt
);

   logic [XLEN-1:0] regs_q [NREGS];
   logic [XLEN-1:0] regs_d [NREGS];
   logic [NREGS-1:0] pend_q, pend_d;
   logic [AW:0]      cnt_q, cnt_d;

   logic hit_a1, hit_b1, hit_a2, hit_b2;

   always_comb begin
      regs_d = regs_q;
      // port B applied first so port A overrides on a shared address
      if (we_b && wa_b != '0) regs_d[wa_b] = wd_b;
      if (we_a && wa_a != '0) regs_d[wa_a] = wd_a;
   end

   always_comb begin
      pend_d = pend_q;
      pend_d[0] = 1'b0;
      for (int r = 1; r < NREGS; r++) begin
         if (flush)
            pend_d[r] = 1'b0;
         else if (iss_valid && iss_rd == AW'(r))
            pend_d[r] = 1'b1;
         else if ((we_a && wa_a == AW'(r)) ||
                  (we_b && wa_b == AW'(r)))
            pend_d[r] = 1'b0;
      end
   end

   always_comb begin
      cnt_d = '0;
      for (int r = 0; r < NREGS; r++)
         cnt_d = cnt_d + {{AW{1'b0}}, pend_d[r]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++)
            regs_q[i] <= '0;
         pend_q <= '0;
         cnt_q  <= '0;
      end else begin
         regs_q <= regs_d;
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
      end
   end

   always_comb begin
      hit_a1 = we_a && wa_a == ra1;
      hit_b1 = we_b && wa_b == ra1;
      hit_a2 = we_a && wa_a == ra2;
      hit_b2 = we_b && wa_b == ra2;
   end

   always_comb begin
      if (ra1 == '0)  rd1 = '0;
      else if (hit_a1) rd1 = wd_a;
      else if (hit_b1) rd1 = wd_b;
      else             rd1 = regs_q[ra1];
      if (ra2 == '0)  rd2 = '0;
      else if (hit_a2) rd2 = wd_a;
      else if (hit_b2) rd2 = wd_b;
      else             rd2 = regs_q[ra2];
   end

   // bypassed data is already valid, so a write hit masks pending
   assign rd_pend1 = (ra1 != '0) && pend_q[ra1] &&
                     !(hit_a1 || hit_b1);
   assign rd_pend2 = (ra2 != '0) && pend_q[ra2] &&
                     !(hit_a2 || hit_b2);

   assign pend_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed vector bench for regfile_sb: data path, bypass,
// scoreboard, flush and asynchronous reset.
module tb_regfile_sb;

   logic        clk;
   logic        rst_n;
   logic [4:0]  ra1, ra2;
   logic [31:0] rd1, rd2;
   logic        rd_pend1, rd_pend2;
   logic        we_a, we_b;
   logic [4:0]  wa_a, wa_b;
   logic [31:0] wd_a, wd_b;
   logic        iss_valid;
   logic [4:0]  iss_rd;
   logic        flush;
   logic [5:0]  pend_cnt;

   int checks;
   int errors;

   regfile_sb #(.XLEN(32), .NREGS(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .ra1(ra1), .ra2(ra2),
      .rd1(rd1), .rd2(rd2),
      .rd_pend1(rd_pend1), .rd_pend2(rd_pend2),
      .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
      .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
      .iss_valid(iss_valid), .iss_rd(iss_rd),
      .flush(flush), .pend_cnt(pend_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int we_a; int wa_a; int wd_a;
      int we_b; int wa_b; int wd_b;
      int iss;  int ird;  int fl;
      int ra1;  int ra2;
      int e1;   int e2;
      int ep1;  int ep2;  int ecnt;
   } vec_t;

   vec_t vecs [23];

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      we_a = 0; wa_a = 0; wd_a = 0;
      we_b = 0; wa_b = 0; wd_b = 0;
      iss_valid = 0; iss_rd = 0; flush = 0;
   endtask

   initial begin
      //          wea waa wda  web wab wdb  iss ird fl ra1 ra2  e1 e2 p1 p2 cnt
      vecs[0]  = '{0,0,0,          0,0,0,          0,0,0, 5,0,  0,0,0,0,0};
      vecs[1]  = '{1,7,32'h11,     1,7,32'h22,     0,0,0, 7,0,  32'h11,0,0,0,0};
      vecs[2]  = '{0,0,0,          0,0,0,          0,0,0, 7,7,  32'h11,32'h11,0,0,0};
      vecs[3]  = '{1,0,32'hFFFFFFFF,0,0,0,         1,0,0, 0,0,  0,0,0,0,0};
      vecs[4]  = '{0,0,0,          0,0,0,          0,0,0, 0,0,  0,0,0,0,0};
      vecs[5]  = '{0,0,0,          0,0,0,          1,3,0, 3,0,  0,0,0,0,1};
      vecs[6]  = '{0,0,0,          0,0,0,          0,0,0, 3,0,  0,0,1,0,1};
      vecs[7]  = '{0,0,0,          1,3,32'h55,     0,0,0, 3,3,  32'h55,32'h55,0,0,0};
      vecs[8]  = '{0,0,0,          0,0,0,          0,0,0, 3,0,  32'h55,0,0,0,0};
      vecs[9]  = '{0,0,0,          0,0,0,          1,9,0, 9,0,  0,0,0,0,1};
      vecs[10] = '{1,9,32'h99,     0,0,0,          1,9,0, 9,0,  32'h99,0,0,0,1};
      vecs[11] = '{0,0,0,          0,0,0,          0,0,0, 9,0,  32'h99,0,1,0,1};
      vecs[12] = '{1,9,32'hA,      0,0,0,          0,0,0, 9,0,  32'hA,0,0,0,0};
      vecs[13] = '{0,0,0,          0,0,0,          1,1,0, 0,0,  0,0,0,0,1};
      vecs[14] = '{0,0,0,          0,0,0,          1,2,0, 1,0,  0,0,1,0,2};
      vecs[15] = '{0,0,0,          0,0,0,          1,4,0, 2,1,  0,0,1,1,3};
      vecs[16] = '{0,0,0,          1,10,32'h77,    1,6,1, 4,10, 0,32'h77,1,0,0};
      vecs[17] = '{0,0,0,          0,0,0,          0,0,0, 6,10, 0,32'h77,0,0,0};
      vecs[18] = '{1,12,32'h12,    1,13,32'h13,    0,0,0, 13,12,32'h13,32'h12,0,0,0};
      vecs[19] = '{0,0,0,          0,0,0,          0,0,0, 12,13,32'h12,32'h13,0,0,0};
      vecs[20] = '{0,0,0,          1,14,32'h14,    1,14,0,14,0, 32'h14,0,0,0,1};
      vecs[21] = '{0,0,0,          0,0,0,          0,0,0, 14,1, 32'h14,0,1,0,1};
      vecs[22] = '{1,14,32'hAA,    1,14,32'hBB,    0,0,0, 14,14,32'hAA,32'hAA,0,0,0};

      checks = 0;
      errors = 0;
      idle_inputs();
      ra1 = 0; ra2 = 0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 23; i++) begin
         @(negedge clk);
         we_a = vecs[i].we_a[0];
         wa_a = 5'(vecs[i].wa_a);
         wd_a = 32'(vecs[i].wd_a);
         we_b = vecs[i].we_b[0];
         wa_b = 5'(vecs[i].wa_b);
         wd_b = 32'(vecs[i].wd_b);
         iss_valid = vecs[i].iss[0];
         iss_rd = 5'(vecs[i].ird);
         flush = vecs[i].fl[0];
         ra1 = 5'(vecs[i].ra1);
         ra2 = 5'(vecs[i].ra2);
         #2;
         check($sformatf("v%0d rd1", i), rd1,
               32'(vecs[i].e1));
         check($sformatf("v%0d rd2", i), rd2,
               32'(vecs[i].e2));
         check($sformatf("v%0d pend1", i),
               {31'b0, rd_pend1}, 32'(vecs[i].ep1));
         check($sformatf("v%0d pend2", i),
               {31'b0, rd_pend2}, 32'(vecs[i].ep2));
         @(posedge clk);
         #1;
         check($sformatf("v%0d cnt", i),
               {26'b0, pend_cnt}, 32'(vecs[i].ecnt));
      end

      // asynchronous reset between edges
      @(negedge clk);
      idle_inputs();
      we_a = 1; wa_a = 5; wd_a = 32'hDEADBEEF;
      iss_valid = 1; iss_rd = 8;
      ra1 = 5; ra2 = 8;
      @(posedge clk);
      #1;
      idle_inputs();
      #1;
      check("rst pre rd1", rd1, 32'hDEADBEEF);
      check("rst pre pend2", {31'b0, rd_pend2}, 32'd1);
      check("rst pre cnt", {26'b0, pend_cnt}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst rd1", rd1, 32'd0);
      check("rst pend2", {31'b0, rd_pend2}, 32'd0);
      check("rst cnt", {26'b0, pend_cnt}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post rst rd1", rd1, 32'd0);
      check("post rst cnt", {26'b0, pend_cnt}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised integer register file with a per-register pending scoreboard for the RISC-V pipeline; next generation of the core register file. Adds two write ports (ALU writeback and load/long-latency writeback), same-cycle write-to-read bypass, an asynchronous clear of all state, and a scoreboard that marks registers awaiting a result. Sits between decode (reads, issue) and writeback (writes); decode stalls on rd_pend*.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (power of two, >=2); register 0 hardwired to zero
AW, $clog2(NREGS), address width (derived localparam, not overridable)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-low
ra1  in  AW  read address, port 1
ra2  in  AW  read address, port 2
rd1  out  XLEN  read data, port 1 (combinational)
rd2  out  XLEN  read data, port 2 (combinational)
rd_pend1  out  1  port 1 register awaits an outstanding write
rd_pend2  out  1  port 2 register awaits an outstanding write
we_a  in  1  write enable, port A (ALU writeback, high priority)
wa_a  in  AW  write address, port A
wd_a  in  XLEN  write data, port A
we_b  in  1  write enable, port B (load writeback, low priority)
wa_b  in  AW  write address, port B
wd_b  in  XLEN  write data, port B
iss_valid  in  1  instruction with destination issued this cycle
iss_rd  in  AW  destination register of issued instruction
flush  in  1  clear all pending bits (pipeline flush)
pend_cnt  out  AW+1  number of registers currently pending (registered)

Behaviour:
- Reset (rst_n=0, async): all NREGS registers cleared to 0, all pending bits 0, pend_cnt=0; rd1/rd2 read 0, rd_pend1/2 read 0. Reset asserted mid-operation takes effect immediately, regardless of clk.
- Writes: on rising edge, port A commits wd_a to wa_a if we_a; port B commits wd_b to wa_b if we_b. Both ports active on the same address: port A wins, port B discarded. Writes to address 0 ignored.
- Reads (combinational, zero latency): address 0 -> data 0, pend 0. Else if we_a && wa_a==addr -> wd_a; else if we_b && wa_b==addr -> wd_b (bypass); else stored value.
- Scoreboard, per register r!=0, at rising edge, priority high to low:
  1. flush=1 -> pending[r]=0 (writes in the same cycle still commit data).
  2. iss_valid && iss_rd==r -> pending[r]=1 (a new producer overrides a same-cycle writeback clear).
  3. (we_a && wa_a==r) || (we_b && wa_b==r) -> pending[r]=0.
  4. otherwise hold.
  iss_valid with iss_rd=0 has no effect.
- rd_pendN = pending[raN] && !(write hit on raN this cycle); i.e. bypassed data counts as valid. Address 0 never pending.
- pend_cnt: registered population count of the pending vector, updated same edge as the vector; range 0..NREGS-1.
- No handshake back-pressure; the block always accepts writes and issues. A write to a non-pending register is legal and just updates data.

Test Plan:
- Reset: write 0xDEADBEEF to x5, assert rst_n=0 between edges -> rd1 (ra1=5) reads 0 immediately, pend_cnt=0.
- Port conflict + bypass: we_a: x7<=0x11, we_b: x7<=0x22 same cycle, ra1=7 -> rd1=0x11 combinationally that cycle and 0x11 after the edge; ra2=0 -> rd2=0.
- x0 protection: we_a wa_a=0 wd_a=0xFFFFFFFF, iss_valid iss_rd=0 -> rd1(ra1=0)=0, rd_pend1=0, pend_cnt unchanged.
- Scoreboard: issue x3 -> next cycle rd_pend1(ra1=3)=1, pend_cnt=1; we_b x3<=0x55 -> that cycle rd_pend1=0, rd1=0x55; after edge pend_cnt=0.
- Issue/writeback collision: iss_rd=9 and we_a wa_a=9 same edge (x9 already pending) -> x9 data updated, pending[9] stays 1, pend_cnt unchanged.
- Flush: issue x1,x2,x4 over three cycles (pend_cnt=3), then flush with iss_valid iss_rd=6 -> after edge pend_cnt=0, rd_pend for x6 =0.
